// File: rtl/lcd_refresh_pkg.sv
// Shared types, panel command codes and the power-up command ROM for the
// character-LCD refresh controller.
package lcd_refresh_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2,
    ST_FIN
  } state_e;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_PULSE,
    BUS_WAIT,
    BUS_DONE
  } bus_state_e;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DDRAM_L1 = 8'h80;
  localparam logic [7:0] DDRAM_L2 = 8'hC0;
  localparam logic [7:0] SPACE    = 8'h20;

  localparam int INIT_LEN = 6;

  typedef struct packed {
    logic [7:0] code;
    logic       long_wait;
  } init_entry_t;

  function automatic init_entry_t init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return '{code: FUNC_SET, long_wait: 1'b1};
      3'd3:             return '{code: DISP_ON,  long_wait: 1'b0};
      3'd4:             return '{code: CLEAR,    long_wait: 1'b1};
      default:          return '{code: ENTRY,    long_wait: 1'b0};
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: setup, enable pulse, then a settle wait that is
// either the normal command time or the long clear/function-set time.
module lcd_bus_cycle
  import lcd_refresh_pkg::*;
#(
  parameter int T_SETUP   = 3,
  parameter int T_EN_HIGH = 25,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int CNT_W     = 17
) (
  input  logic       clk_0,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_i,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o,
  output logic       done_o
);

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_last;
  logic             long_q, long_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;

  assign wait_last = long_q ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    unique case (state_q)
      // DONE accepts a new start so consecutive bytes are back to back.
      BUS_IDLE, BUS_DONE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = BUS_SETUP;
          rs_d    = rs_i;
          data_d  = data_i;
          long_d  = long_i;
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_SETUP: if (cnt_q == CNT_W'(T_SETUP - 1)) begin
        state_d = BUS_PULSE;
        cnt_d   = '0;
      end
      BUS_PULSE: if (cnt_q == CNT_W'(T_EN_HIGH - 1)) begin
        state_d = BUS_WAIT;
        cnt_d   = '0;
      end
      BUS_WAIT: if (cnt_q == wait_last) begin
        state_d = BUS_DONE;
        cnt_d   = '0;
      end
      default: state_d = BUS_IDLE;
    endcase
    en_d = (state_d == BUS_PULSE);
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign lcd_en_o   = en_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;
  assign done_o     = (state_q == BUS_DONE);

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// 16x2 character LCD owner: runs panel init, then repaints the whole 32-byte
// shadow buffer whenever the host has written to it.
module lcd_refresh_ctrl
  import lcd_refresh_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 3,
  parameter int T_EN_HIGH = 25,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic       clk_0,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       busy,
  output logic       frame_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int CNT_W = $clog2(max_int(T_POWERUP, T_CLEAR) + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pwr_q, pwr_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       col_q, col_d;
  logic             init_done_q, init_done_d;
  logic             dirty_q, dirty_d;
  logic [7:0]       buf_q [32];

  logic       bus_start, bus_rs, bus_long, bus_done;
  logic [7:0] bus_data;
  logic       pwr_last, idx_last, col_last;

  assign pwr_last = (pwr_q == CNT_W'(T_POWERUP - 1));
  assign idx_last = (idx_q == 3'(INIT_LEN - 1));
  assign col_last = (col_q == 4'd15);

  // NOTE: the buffer must power up as spaces, so it is reset flops, not a RAM.
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= SPACE;
    end else if (wr_en) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_POWERUP;
      pwr_q       <= '0;
      idx_q       <= '0;
      col_q       <= '0;
      init_done_q <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= pwr_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      init_done_q <= init_done_d;
      dirty_q     <= dirty_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwr_d       = pwr_q;
    idx_d       = idx_q;
    col_d       = col_q;
    init_done_d = init_done_q;
    dirty_d     = dirty_q;
    unique case (state_q)
      ST_POWERUP: if (pwr_last) begin
        state_d = ST_INIT;
        idx_d   = '0;
      end else begin
        pwr_d = pwr_q + 1'b1;
      end
      ST_INIT: if (bus_done) begin
        if (idx_last) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_IDLE: if (dirty_q) begin
        state_d = ST_ADDR1;
        dirty_d = 1'b0;
      end
      ST_ADDR1: if (bus_done) begin
        state_d = ST_LINE1;
        col_d   = '0;
      end
      ST_LINE1: if (bus_done) begin
        if (col_last) state_d = ST_ADDR2;
        else          col_d   = col_q + 4'd1;
      end
      ST_ADDR2: if (bus_done) begin
        state_d = ST_LINE2;
        col_d   = '0;
      end
      ST_LINE2: if (bus_done) begin
        if (col_last) state_d = ST_FIN;
        else          col_d   = col_q + 4'd1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_POWERUP;
    endcase
    // A write in the same cycle IDLE consumes dirty keeps it set.
    if (wr_en) dirty_d = 1'b1;
  end

  // Each byte is issued in the cycle its predecessor reports done, so the
  // buffer is sampled exactly when the bus cycle enters SETUP.
  always_comb begin
    bus_start = 1'b0;
    bus_rs    = 1'b0;
    bus_data  = 8'h00;
    bus_long  = 1'b0;
    unique case (state_q)
      ST_POWERUP: if (pwr_last) begin
        bus_start            = 1'b1;
        {bus_data, bus_long} = init_rom(3'd0);
      end
      ST_INIT: if (bus_done && !idx_last) begin
        bus_start            = 1'b1;
        {bus_data, bus_long} = init_rom(idx_q + 3'd1);
      end
      ST_IDLE: if (dirty_q) begin
        bus_start = 1'b1;
        bus_data  = DDRAM_L1;
      end
      ST_ADDR1: if (bus_done) begin
        bus_start = 1'b1;
        bus_rs    = 1'b1;
        bus_data  = buf_q[5'd0];
      end
      ST_LINE1: if (bus_done) begin
        bus_start = 1'b1;
        if (col_last) begin
          bus_data = DDRAM_L2;
        end else begin
          bus_rs   = 1'b1;
          bus_data = buf_q[{1'b0, col_q + 4'd1}];
        end
      end
      ST_ADDR2: if (bus_done) begin
        bus_start = 1'b1;
        bus_rs    = 1'b1;
        bus_data  = buf_q[5'd16];
      end
      ST_LINE2: if (bus_done && !col_last) begin
        bus_start = 1'b1;
        bus_rs    = 1'b1;
        bus_data  = buf_q[{1'b1, col_q + 4'd1}];
      end
      default: ;
    endcase
  end

  lcd_bus_cycle #(
    .T_SETUP  (T_SETUP),
    .T_EN_HIGH(T_EN_HIGH),
    .T_CMD    (T_CMD),
    .T_CLEAR  (T_CLEAR),
    .CNT_W    (CNT_W)
  ) u_bus (
    .clk_0     (clk_0),
    .reset     (reset),
    .start_i   (bus_start),
    .rs_i      (bus_rs),
    .data_i    (bus_data),
    .long_i    (bus_long),
    .lcd_en_o  (LCD_EN),
    .lcd_rs_o  (LCD_RS),
    .lcd_data_o(LCD_DATA),
    .done_o    (bus_done)
  );

  assign init_done  = init_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_FIN);
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = 1'b1;
  assign LCD_RW     = 1'b0;

endmodule
